// File: rtl/shift_pkg.sv
// Shared definitions for the iterative 64-bit shifters (left and right).
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package shift_pkg;

  localparam int DATA_W  = 64;
  localparam int SHIFT_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } shift_state_t;

  // Cycles per operation: six binary-weighted stages split into groups of step_bits.
  function automatic int calc_lat(input int step_bits);
    return SHIFT_W / step_bits;
  endfunction

endpackage

// File: rtl/srl_stage.sv
// Single right-shift stage: shifts by 2**K when enabled, vacated MSBs take the fill bit.
// Latency: purely combinational.
// Backpressure: none.
// Ports: i_data operand, i_en stage enable (shift bit K), i_fill fill bit, o_data result.
module srl_stage
  import shift_pkg::*;
#(
  parameter int K = 0
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_en,
  input  logic              i_fill,
  output logic [DATA_W-1:0] o_data
);

  localparam int SH = 1 << K;

  always_comb begin
    o_data = i_data;
    if (i_en) begin
      o_data = {{SH{i_fill}}, i_data[DATA_W-1:SH]};
    end
  end

endmodule

// File: rtl/srl_64b_iter.sv
// Iterative 64-bit logical/arithmetic right shifter, STEP_BITS stages applied per cycle.
// Latency: 6/STEP_BITS cycles from accepted init_i to the done_o pulse; one op per latency.
// Backpressure: init_i is ignored (not queued) while busy_o is high.
// Ports: clk_i, rst_i (sync, active-high); init_i start; arith_i arithmetic mode;
//        shift_i amount; data_i operand; busy_o in progress; done_o completion pulse;
//        data_o result, held until the next completion.
module srl_64b_iter
  import shift_pkg::*;
#(
  parameter int   STEP_BITS = 6,
  parameter logic ARITH_EN  = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               init_i,
  input  logic               arith_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic [DATA_W-1:0]  data_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [DATA_W-1:0]  data_o
);

  localparam int L = calc_lat(STEP_BITS);

  if (!(STEP_BITS == 1 || STEP_BITS == 2 || STEP_BITS == 3 || STEP_BITS == 6)) begin : g_bad_step
    $error("srl_64b_iter: STEP_BITS must be 1, 2, 3 or 6");
  end

  shift_state_t       r_state;
  logic [2:0]         r_cnt;
  logic [SHIFT_W-1:0] r_shift;
  logic               r_fill;
  logic [DATA_W-1:0]  r_work;
  logic [DATA_W-1:0]  r_data;
  logic               r_done;

  logic               w_idle;
  logic               w_last;
  logic [2:0]         w_grp;
  logic [SHIFT_W-1:0] w_shamt;
  logic               w_fill;
  logic [DATA_W-1:0]  w_src;
  logic [DATA_W-1:0]  w_next;
  logic [DATA_W-1:0]  w_grp_out [L];

  // In IDLE the datapath works straight off the inputs so group 0 is applied
  // in the acceptance cycle; in RUN it works off the captured operands.
  assign w_idle  = (r_state == IDLE);
  assign w_grp   = w_idle ? 3'd0 : r_cnt;
  assign w_shamt = w_idle ? shift_i : r_shift;
  assign w_fill  = w_idle ? (ARITH_EN & arith_i & data_i[DATA_W-1]) : r_fill;
  assign w_src   = w_idle ? data_i : r_work;
  assign w_last  = (w_grp == 3'(L - 1));

  // Each stage exists once; group g chains stages g*STEP_BITS .. g*STEP_BITS+STEP_BITS-1.
  for (genvar g = 0; g < L; g++) begin : g_grp
    logic [DATA_W-1:0] w_chain [STEP_BITS+1];
    assign w_chain[0] = w_src;
    for (genvar j = 0; j < STEP_BITS; j++) begin : g_stage
      srl_stage #(
        .K(g * STEP_BITS + j)
      ) u_stage (
        .i_data(w_chain[j]),
        .i_en  (w_shamt[g * STEP_BITS + j]),
        .i_fill(w_fill),
        .o_data(w_chain[j+1])
      );
    end
    assign w_grp_out[g] = w_chain[STEP_BITS];
  end

  always_comb begin
    w_next = w_grp_out[0];
    for (int g = 0; g < L; g++) begin
      if (w_grp == 3'(g)) begin
        w_next = w_grp_out[g];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_shift <= '0;
      r_fill  <= 1'b0;
      r_work  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (init_i) begin
            r_shift <= shift_i;
            r_fill  <= w_fill;
            if (w_last) begin
              // Single-cycle configuration: finish without entering RUN.
              r_data <= w_next;
              r_done <= 1'b1;
            end else begin
              r_work  <= w_next;
              r_cnt   <= 3'd1;
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_last) begin
            r_data  <= w_next;
            r_done  <= 1'b1;
            r_cnt   <= 3'd0;
            r_state <= IDLE;
          end else begin
            r_work <= w_next;
            r_cnt  <= r_cnt + 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o = (r_state == RUN);
  assign done_o = r_done;
  assign data_o = r_data;

endmodule

// File: tb/tb_srl_64b_iter.sv
// Bench for srl_64b_iter: several configurations side by side, shared operand bus,
// per-instance init, completions checked against a queue of expected results.
module tb_srl_64b_iter;

  localparam int NI = 5;

  typedef struct {
    int          id;
    logic [63:0] d;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        arith;
  logic [5:0]  shift;
  logic [63:0] data;
  logic        init [NI];
  logic        busy [NI];
  logic        done [NI];
  logic [63:0] dout [NI];

  int   cyc;
  int   n_chk;
  int   n_fail;
  exp_t exp_q [$];
  exp_t mon_e;

  // 0: S=6, 1: S=1, 2: S=2 zero-fill only, 3: S=3, 4: S=2
  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int   S = (gi == 0) ? 6 : (gi == 1) ? 1 : (gi == 2) ? 2 : (gi == 3) ? 3 : 2;
    localparam logic A = (gi == 2) ? 1'b0 : 1'b1;
    srl_64b_iter #(
      .STEP_BITS(S),
      .ARITH_EN (A)
    ) u_dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .init_i (init[gi]),
      .arith_i(arith),
      .shift_i(shift),
      .data_i (data),
      .busy_o (busy[gi]),
      .done_o (done[gi]),
      .data_o (dout[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int i);
    case (i)
      0:       return 1;
      1:       return 6;
      3:       return 2;
      default: return 3;
    endcase
  endfunction

  // Completion monitor
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (done[i] === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done inst %0d: got completion with data %h at cycle %0d, required none",
                   i, dout[i], cyc);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.id != i || mon_e.d !== dout[i] || mon_e.cyc != cyc) begin
            n_fail++;
            $display("FAIL done_result: got inst %0d data %h cycle %0d, required inst %0d data %h cycle %0d",
                     i, dout[i], cyc, mon_e.id, mon_e.d, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  // Called at a negedge; returns at the negedge of cycle N+1 with init dropped.
  task automatic issue(input int i, input logic [63:0] d, input logic [5:0] sh, input logic ar,
                       input bit expect_done, input logic [63:0] exp);
    exp_t e;
    data    = d;
    shift   = sh;
    arith   = ar;
    init[i] = 1'b1;
    if (expect_done) begin
      e.id  = i;
      e.d   = exp;
      e.cyc = cyc + lat(i);
      exp_q.push_back(e);
    end
    @(negedge clk);
    init[i] = 1'b0;
  endtask

  // From cycle N+1: busy through N+L-1, low at N+L (the done cycle).
  task automatic watch_busy(input int i);
    for (int k = 1; k < lat(i); k++) begin
      check($sformatf("busy_run_inst%0d_k%0d", i, k), {63'b0, busy[i]}, 64'd1);
      @(negedge clk);
    end
    check($sformatf("busy_end_inst%0d", i), {63'b0, busy[i]}, 64'd0);
  endtask

  task automatic rand_ops(input int i, input int n);
    logic [63:0]        d;
    logic signed [63:0] sd;
    logic [63:0]        exp;
    logic [5:0]         sh;
    logic               ar;
    for (int k = 0; k < n; k++) begin
      d  = {$urandom(), $urandom()};
      sh = 6'($urandom_range(0, 63));
      ar = 1'($urandom_range(0, 1));
      sd = d;
      sd = sd >>> sh;
      if (ar) exp = sd;
      else    exp = d >> sh;
      issue(i, d, sh, ar, 1'b1, exp);
      repeat (lat(i) - 1) @(negedge clk);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    arith  = 1'b0;
    shift  = '0;
    data   = '0;
    for (int i = 0; i < NI; i++) init[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NI; i++) begin
      check($sformatf("reset_busy_inst%0d", i), {63'b0, busy[i]}, 64'd0);
      check($sformatf("reset_done_inst%0d", i), {63'b0, done[i]}, 64'd0);
      check($sformatf("reset_data_inst%0d", i), dout[i], 64'd0);
    end

    // Single-cycle logical shift, then hold of data_o
    issue(0, 64'hF000_0000_0000_0001, 6'd4, 1'b0, 1'b1, 64'h0F00_0000_0000_0000);
    watch_busy(0);
    repeat (2) @(negedge clk);
    check("hold_data_inst0", dout[0], 64'h0F00_0000_0000_0000);
    check("hold_done_low_inst0", {63'b0, done[0]}, 64'd0);
    issue(0, 64'h8000_0000_0000_0001, 6'd63, 1'b0, 1'b1, 64'h0000_0000_0000_0001);
    watch_busy(0);
    @(negedge clk);

    // Six-cycle arithmetic shift by 63
    issue(1, 64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    watch_busy(1);
    @(negedge clk);

    // Sign fill disabled at build time: arith_i ignored
    issue(2, 64'h8000_0000_0000_0000, 6'd1, 1'b1, 1'b1, 64'h4000_0000_0000_0000);
    watch_busy(2);
    @(negedge clk);
    issue(2, 64'hFFFF_0000_0000_0000, 6'd63, 1'b1, 1'b1, 64'h0000_0000_0000_0001);
    watch_busy(2);
    @(negedge clk);

    // init while busy is dropped; init in the done cycle is taken
    issue(3, 64'hDEAD_BEEF_0000_FFFF, 6'd16, 1'b0, 1'b1, 64'h0000_DEAD_BEEF_0000);
    check("busy_before_ignored_init", {63'b0, busy[3]}, 64'd1);
    data    = 64'h1111_2222_3333_4444;
    shift   = 6'd1;
    arith   = 1'b1;
    init[3] = 1'b1;
    @(negedge clk);
    init[3] = 1'b0;
    issue(3, 64'hC000_0000_0000_0000, 6'd4, 1'b1, 1'b1, 64'hFC00_0000_0000_0000);
    watch_busy(3);
    repeat (4) @(negedge clk);

    // Reset mid-operation aborts; then shift by zero
    issue(1, 64'hAAAA_5555_AAAA_5555, 6'd3, 1'b0, 1'b0, 64'd0);
    @(negedge clk);
    check("abort_busy_before", {63'b0, busy[1]}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {63'b0, busy[1]}, 64'd0);
    check("abort_done", {63'b0, done[1]}, 64'd0);
    check("abort_data", dout[1], 64'd0);
    repeat (8) @(negedge clk);
    issue(1, 64'h1234_5678_9ABC_DEF0, 6'd0, 1'b0, 1'b1, 64'h1234_5678_9ABC_DEF0);
    watch_busy(1);
    @(negedge clk);

    // Back-to-back random operations at full throughput
    rand_ops(0, 200);
    @(negedge clk);
    rand_ops(1, 200);
    @(negedge clk);
    rand_ops(3, 200);
    @(negedge clk);
    rand_ops(4, 200);
    repeat (8) @(negedge clk);

    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
